// File: rtl/imem_pkg.sv
// imem_pkg: shared state encoding and constants for the instruction-memory boot loader.
`default_nettype none

package imem_pkg;

  localparam int IMEM_ADDR_W    = 10;
  localparam int BYTES_PER_WORD = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RECV  = 3'd1,
    WRITE = 3'd2,
    DONE  = 3'd3,
    ERROR = 3'd4
  } state_t;

endpackage

`default_nettype wire

// File: rtl/imem_byte_serializer.sv
// imem_byte_serializer: holds the accepted word and emits it one byte per cycle, LSB first.
`default_nettype none

module imem_byte_serializer
  import imem_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        i_load,
  input  logic [31:0] i_word,
  input  logic        i_advance,
  output logic [7:0]  o_wdata,
  output logic        o_idx_last
);

  logic [31:0] r_word;
  logic [1:0]  r_idx;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_word <= 32'd0;
      r_idx  <= 2'd0;
    end else if (i_load) begin
      r_word <= i_word;
      r_idx  <= 2'd0;
    end else if (i_advance) begin
      r_idx  <= r_idx + 2'd1;
    end
  end

  assign o_wdata    = r_word[{r_idx, 3'b000} +: 8];
  assign o_idx_last = (r_idx == 2'(BYTES_PER_WORD - 1));

endmodule

`default_nettype wire

// File: rtl/imem_boot_loader.sv
// imem_boot_loader: loads a 32-bit word stream into byte-wide instruction memory, stalling the core.
// Optional checksum output enabled by defining IMEM_LOAD_CHECKSUM_EN.
`default_nettype none

module imem_boot_loader
  import imem_pkg::*;
#(
  parameter int ADDR_W    = IMEM_ADDR_W,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              load_valid,
  input  logic [31:0]       load_data,
  input  logic              load_last,
  output logic              load_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              cpu_stall,
  output logic              done,
  output logic              error,
  output logic [ADDR_W-2:0] word_count
`ifdef IMEM_LOAD_CHECKSUM_EN
  ,
  output logic [31:0]       checksum
`endif
);

  localparam logic [ADDR_W-1:0] c_base_addr = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] c_last_word = ADDR_W'((1 << ADDR_W) - BYTES_PER_WORD);

  state_t              r_state;
  state_t              w_next;
  logic [ADDR_W-1:0]   r_ptr;
  logic                r_wrap;
  logic                r_last;
  logic [ADDR_W-2:0]   r_word_count;
  logic                w_accept;
  logic                w_overflow;
  logic                w_start_ok;
  logic                w_idx_last;
  logic                w_writing;

  assign w_writing  = (r_state == WRITE);
  assign w_accept   = (r_state == RECV) && load_valid;
  // r_wrap remembers that the top byte was written, since ptr itself wraps to 0
  assign w_overflow = r_wrap || (r_ptr > c_last_word);
  assign w_start_ok = start && ((r_state == IDLE) || (r_state == DONE) || (r_state == ERROR));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = RECV;
      RECV:    if (w_accept) w_next = w_overflow ? ERROR : WRITE;
      WRITE:   if (w_idx_last) w_next = r_last ? DONE : RECV;
      DONE:    if (start) w_next = RECV;
      ERROR:   if (start) w_next = RECV;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ptr        <= '0;
      r_wrap       <= 1'b0;
      r_last       <= 1'b0;
      r_word_count <= '0;
    end else if (w_start_ok) begin
      r_ptr        <= c_base_addr;
      r_wrap       <= 1'b0;
      r_word_count <= '0;
    end else begin
      if (w_accept && !w_overflow) r_last <= load_last;
      if (w_writing) begin
        if (r_ptr == '1) r_wrap <= 1'b1;
        r_ptr <= r_ptr + ADDR_W'(1);
        if (w_idx_last) r_word_count <= r_word_count + (ADDR_W-1)'(1);
      end
    end
  end

`ifdef IMEM_LOAD_CHECKSUM_EN
  logic [31:0] r_sum;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                    r_sum <= 32'd0;
    else if (w_start_ok)             r_sum <= 32'd0;
    else if (w_accept && !w_overflow) r_sum <= r_sum + load_data;
  end

  assign checksum = r_sum;
`endif

  imem_byte_serializer u_ser (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_load     (w_accept && !w_overflow),
    .i_word     (load_data),
    .i_advance  (w_writing),
    .o_wdata    (mem_wdata),
    .o_idx_last (w_idx_last)
  );

  assign load_ready = (r_state == RECV);
  assign mem_we     = w_writing;
  assign mem_addr   = r_ptr;
  assign cpu_stall  = (r_state != DONE);
  assign done       = (r_state == DONE);
  assign error      = (r_state == ERROR);
  assign word_count = r_word_count;

endmodule

`default_nettype wire

// File: doc/imem_boot_loader.md
# imem_boot_loader

Sequencing controller that fills the byte-wide instruction memory from a 32-bit word stream before the RV32I core runs. It accepts words over a valid/ready handshake and writes each word little-endian as four consecutive byte writes. It holds the core stalled until the image is complete. It sits between the host/debug load port and the instruction-memory write port, alongside the core's fetch path.

## Interface
Parameters:
- ADDR_W, 10: byte address width of instruction memory (depth 2^ADDR_W bytes).
- BASE_ADDR, 0: first byte address written; must be a multiple of 4.

Ports:
- clk  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a load from BASE_ADDR.
- load_valid  in  1  load_data/load_last valid.
- load_data  in  32  instruction word, little-endian byte order.
- load_last  in  1  marks final word of the image.
- load_ready  out  1  controller can accept a word this cycle.
- mem_we  out  1  byte write strobe to instruction memory.
- mem_addr  out  ADDR_W  byte address of the write.
- mem_wdata  out  8  byte written.
- cpu_stall  out  1  holds core fetch/PC while high.
- done  out  1  image loaded, level, until next start.
- error  out  1  overflow, level, until next start or reset.
- word_count  out  ADDR_W-1  words written in the current load.

## Operation
- States: IDLE, RECV, WRITE, DONE, ERROR.
- **IDLE** (after reset): cpu_stall=1, load_ready=0. start -> RECV, ptr=BASE_ADDR, word_count=0.
- **RECV**: load_ready=1.
  - load_valid & load_ready -> latch load_data and load_last, byte index=0, go to WRITE.
  - If no valid word arrives, stay in RECV.
- **WRITE**: mem_we=1 for exactly 4 cycles.
  - mem_addr=ptr; mem_wdata=word[8*idx+7:8*idx]; ptr and idx increment each cycle.
  - After idx=3: word_count increments.
  - If the latched last bit is set -> DONE; otherwise -> RECV.
- **DONE**: cpu_stall=0, done=1. start -> RECV, reasserts cpu_stall and clears done.
- **Overflow**: a word is accepted in RECV when ptr > 2^ADDR_W-4.
  - The word is accepted and dropped; no writes are issued.
  - Go to ERROR: error=1, cpu_stall=1.
  - start -> RECV, clears error.
- start while in RECV or WRITE is ignored.
- load_valid outside RECV is ignored; load_ready=0 there.
- ptr arithmetic is ADDR_W bits wide. Overflow is detected before the write, so writes never wrap.
- All outputs are registered or decoded only from state and registers; there are no combinational input-to-output paths.

## Timing
- Reset values: state=IDLE, cpu_stall=1, load_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, done=0, error=0, word_count=0.
- start is sampled at edge N; load_ready=1 from cycle N+1.
- A handshake at edge H produces mem_we at cycles H+1..H+4 and load_ready again at H+5. Sustained throughput is 1 word per 5 cycles.
- For the last word, done=1 and cpu_stall=0 from cycle H+5.
- reset_n low at any time forces reset values immediately, including mid-WRITE. The partial word is abandoned and the memory contents are untouched by the controller.

## Configuration
- IMEM_LOAD_CHECKSUM_EN defined:
  - Adds output checksum[31:0]: the mod-2^32 sum of all accepted, written words.
  - Cleared on reset and on start.
  - Valid when done=1.
- IMEM_LOAD_CHECKSUM_EN undefined: no checksum port and no adder; all other behaviour is identical.

## Structure
- Shared package imem_pkg:
  - State enum (IDLE, RECV, WRITE, DONE, ERROR).
  - IMEM_ADDR_W=10 default.
  - Byte-lane constant BYTES_PER_WORD=4.
- One natural sub-module, imem_byte_serializer: holds the latched word and the index, and drives mem_wdata/idx_last. The FSM stays in the top.

## Test plan
- Reset with ADDR_W=10, BASE_ADDR=0 -> all outputs at reset values and cpu_stall=1.
- Load 0x00500093 then 0x00A00113 (last): bytes 93,00,50,00,13,01,A0,00 written at addresses 0..7 on consecutive mem_we cycles; word_count=2; done=1 and cpu_stall=0 five cycles after the second handshake.
- load_valid deasserted for 3 cycles in RECV -> no mem_we, state held, load_ready stays 1; the load then resumes correctly.
- BASE_ADDR=1016, load 3 words with no last -> addresses 1016..1023 written; the third word raises error=1 with no further mem_we and cpu_stall=1. start then clears error.
- reset_n low after the second byte of a word -> mem_we=0 at once and state=IDLE. After release, start with a new image loads from BASE_ADDR correctly.
- With IMEM_LOAD_CHECKSUM_EN, load 0xFFFFFFFF and 0x00000002 (last) -> checksum=0x00000001 when done=1.
